// File: rtl/frame_seq_param.sv
// -----------------------------------------------------------------------------
// frame_seq_param
// Parametrised APU frame sequencer. Counts APU-cycle ticks (aclk_en) and emits
// one-CLK quarter-frame / half-frame strobes at the configured step points,
// raises the frame IRQ in 4-step mode, and restarts the sequence a fixed
// number of ticks after a $4017 write.
//
// Ports:
//   CLK        in   1  system clock, all state on posedge
//   RES        in   1  synchronous reset, active-high
//   aclk_en    in   1  one-CLK pulse per APU cycle (tick)
//   wr_4017    in   1  $4017 write strobe
//   din        in   2  din[1]=mode (0: 4-step, 1: 5-step), din[0]=IRQ inhibit
//   rd_status  in   1  $4015 read strobe, clears irq_flag
//   pal        in   1  (FRAME_SEQ_PAL_EN only) selects the PSTEP* table
//   qframe     out  1  quarter-frame strobe (registered)
//   hframe     out  1  half-frame strobe (registered)
//   irq_flag   out  1  frame IRQ flag (level)
//   step       out  3  current step index 0..4
//
// Configuration macro: FRAME_SEQ_PAL_EN adds the pal input and the PSTEP1..5
// table. pal is sampled only at reset and whenever the counter returns to 0.
// -----------------------------------------------------------------------------
module frame_seq_param #(
  parameter int CNT_W  = 15,
  parameter int STEP1  = 3728,
  parameter int STEP2  = 7456,
  parameter int STEP3  = 11185,
  parameter int STEP4  = 14914,
  parameter int STEP5  = 18640,
`ifdef FRAME_SEQ_PAL_EN
  parameter int PSTEP1 = 4156,
  parameter int PSTEP2 = 8313,
  parameter int PSTEP3 = 12469,
  parameter int PSTEP4 = 16626,
  parameter int PSTEP5 = 20782,
`endif
  parameter int WR_DLY = 2
) (
  input  logic       CLK,
  input  logic       RES,
  input  logic       aclk_en,
  input  logic       wr_4017,
  input  logic [1:0] din,
  input  logic       rd_status,
`ifdef FRAME_SEQ_PAL_EN
  input  logic       pal,
`endif
  output logic       qframe,
  output logic       hframe,
  output logic       irq_flag,
  output logic [2:0] step
);

  localparam logic [CNT_W-1:0] NS1 = CNT_W'(STEP1);
  localparam logic [CNT_W-1:0] NS2 = CNT_W'(STEP2);
  localparam logic [CNT_W-1:0] NS3 = CNT_W'(STEP3);
  localparam logic [CNT_W-1:0] NS4 = CNT_W'(STEP4);
  localparam logic [CNT_W-1:0] NS5 = CNT_W'(STEP5);
  localparam logic [2:0]       DLY_LOAD = 3'(WR_DLY);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       step_q, step_d;
  logic [2:0]       dly_q, dly_d;
  logic             mode_q, mode_d;
  logic             inh_q, inh_d;
  logic             irq_q, irq_d;
  logic             qf_q, qf_d;
  logic             hf_q, hf_d;
  logic             irq_set_s;
  logic [CNT_W-1:0] s1_s, s2_s, s3_s, s4_s, s5_s, last_s;

`ifdef FRAME_SEQ_PAL_EN
  localparam logic [CNT_W-1:0] PS1 = CNT_W'(PSTEP1);
  localparam logic [CNT_W-1:0] PS2 = CNT_W'(PSTEP2);
  localparam logic [CNT_W-1:0] PS3 = CNT_W'(PSTEP3);
  localparam logic [CNT_W-1:0] PS4 = CNT_W'(PSTEP4);
  localparam logic [CNT_W-1:0] PS5 = CNT_W'(PSTEP5);

  logic pal_q, pal_d;

  assign s1_s = pal_q ? PS1 : NS1;
  assign s2_s = pal_q ? PS2 : NS2;
  assign s3_s = pal_q ? PS3 : NS3;
  assign s4_s = pal_q ? PS4 : NS4;
  assign s5_s = pal_q ? PS5 : NS5;

  // pal is only re-sampled when the counter lands on 0 after a tick, so a
  // table switch never happens mid-frame.
  always_comb begin
    if (aclk_en && (cnt_d == CNT_ZERO)) begin
      pal_d = pal;
    end else begin
      pal_d = pal_q;
    end
  end

  // PAL select register.
  always_ff @(posedge CLK) begin
    if (RES) begin
      pal_q <= pal;
    end else begin
      pal_q <= pal_d;
    end
  end
`else
  assign s1_s = NS1;
  assign s2_s = NS2;
  assign s3_s = NS3;
  assign s4_s = NS4;
  assign s5_s = NS5;
`endif

  // Wrap point of the current mode; anything beyond it (only reachable after a
  // 5-step -> 4-step mode change) restarts the frame silently.
  assign last_s = mode_q ? s5_s : s4_s;

  // Next-state logic: tick handling, $4017 write and IRQ flag.
  always_comb begin
    cnt_d     = cnt_q;
    step_d    = step_q;
    dly_d     = dly_q;
    mode_d    = mode_q;
    inh_d     = inh_q;
    qf_d      = 1'b0;
    hf_d      = 1'b0;
    irq_set_s = 1'b0;

    if (aclk_en) begin
      if (!wr_4017 && (dly_q == 3'd1)) begin
        // Write-delay expiry overrides any step point on this tick.
        cnt_d  = CNT_ZERO;
        step_d = 3'd0;
        dly_d  = 3'd0;
        if (mode_q) begin
          qf_d = 1'b1;
          hf_d = 1'b1;
        end else begin
          qf_d = 1'b0;
          hf_d = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + CNT_ONE;
        if (dly_q != 3'd0) begin
          dly_d = dly_q - 3'd1;
        end else begin
          dly_d = dly_q;
        end
        if (cnt_q == s1_s) begin
          qf_d   = 1'b1;
          step_d = step_q + 3'd1;
        end else if (cnt_q == s2_s) begin
          qf_d   = 1'b1;
          hf_d   = 1'b1;
          step_d = step_q + 3'd1;
        end else if (cnt_q == s3_s) begin
          qf_d   = 1'b1;
          step_d = step_q + 3'd1;
        end else if ((cnt_q == s4_s) && !mode_q) begin
          qf_d      = 1'b1;
          hf_d      = 1'b1;
          irq_set_s = !inh_q;
          cnt_d     = CNT_ZERO;
          step_d    = 3'd0;
        end else if (cnt_q == s4_s) begin
          // 5-step mode: step point 4 is silent but still advances step.
          step_d = step_q + 3'd1;
        end else if ((cnt_q == s5_s) && mode_q) begin
          qf_d   = 1'b1;
          hf_d   = 1'b1;
          cnt_d  = CNT_ZERO;
          step_d = 3'd0;
        end else if (cnt_q > last_s) begin
          cnt_d  = CNT_ZERO;
          step_d = 3'd0;
        end else begin
          step_d = step_q;
        end
      end
    end else begin
      cnt_d = cnt_q;
    end

    // A write (re)arms the delay and takes over any countdown in flight.
    if (wr_4017) begin
      mode_d = din[1];
      inh_d  = din[0];
      dly_d  = DLY_LOAD;
    end else begin
      mode_d = mode_q;
    end

    // Set has priority over both clear sources.
    if (irq_set_s) begin
      irq_d = 1'b1;
    end else if (rd_status || (wr_4017 && din[0])) begin
      irq_d = 1'b0;
    end else begin
      irq_d = irq_q;
    end
  end

  // State and output registers.
  always_ff @(posedge CLK) begin
    if (RES) begin
      cnt_q  <= CNT_ZERO;
      step_q <= 3'd0;
      dly_q  <= 3'd0;
      mode_q <= 1'b0;
      inh_q  <= 1'b0;
      irq_q  <= 1'b0;
      qf_q   <= 1'b0;
      hf_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      step_q <= step_d;
      dly_q  <= dly_d;
      mode_q <= mode_d;
      inh_q  <= inh_d;
      irq_q  <= irq_d;
      qf_q   <= qf_d;
      hf_q   <= hf_d;
    end
  end

  assign qframe   = qf_q;
  assign hframe   = hf_q;
  assign irq_flag = irq_q;
  assign step     = step_q;

endmodule
